// File: rtl/core_despatch.sv
// rtl/core_despatch.sv - 2-entry in-order despatch queue with physical-register scoreboard (optional DESPATCH_BYPASS_EN)
package core_despatch_pkg;
    typedef logic [31:0] micro_op_t;
endpackage

module core_despatch #(
    parameter int NUM_SCHEDULERS    = 2,
    parameter int NUM_PHYSICAL_REGS = 64,
    parameter int NUM_WB_PORTS      = 2,
    localparam int PR_W  = $clog2(NUM_PHYSICAL_REGS),
    localparam int SCH_W = (NUM_SCHEDULERS > 1) ? $clog2(NUM_SCHEDULERS) : 1,
    localparam int UOP_W = $bits(core_despatch_pkg::micro_op_t)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_uop_p,
    input  logic [UOP_W-1:0]             i_uop,
    input  logic [SCH_W-1:0]             i_uop_sched,
    input  logic                         i_uop_dst_we,
    input  logic [PR_W-1:0]              i_uop_dst_pr,
    output logic                         o_stall,
    input  logic [NUM_SCHEDULERS-1:0]    i_sched_full,
    output logic [NUM_SCHEDULERS-1:0]    o_sched_uop_p,
    output logic [UOP_W-1:0]             o_sched_uop,
    input  logic [NUM_WB_PORTS-1:0]      i_wb_p,
    input  logic [NUM_WB_PORTS*PR_W-1:0] i_wb_pr,
    output logic [NUM_PHYSICAL_REGS-1:0] o_pr_valid
);
    logic [UOP_W-1:0]             r_uop [2];
    logic [SCH_W-1:0]             r_sch [2];
    logic                         r_we  [2];
    logic [PR_W-1:0]              r_pr  [2];
    logic                         r_head;
    logic [1:0]                   r_count;
    logic [NUM_PHYSICAL_REGS-1:0] r_pr_valid;
    logic [NUM_PHYSICAL_REGS-1:0] w_pr_next;
    logic                         w_tail;
    logic                         w_head_go;
    logic                         w_bypass;
    logic                         w_push;
    logic                         w_clr_en;
    logic [PR_W-1:0]              w_clr_pr;

    assign w_tail    = r_head ^ r_count[0];
    assign o_stall   = (r_count == 2'd2);
    assign w_head_go = (r_count != 2'd0) && !i_sched_full[r_sch[r_head]];
`ifdef DESPATCH_BYPASS_EN
    // An empty queue lets a ready uop go straight through without occupying a slot.
    assign w_bypass  = (r_count == 2'd0) && i_uop_p && !i_sched_full[i_uop_sched];
`else
    assign w_bypass  = 1'b0;
`endif
    assign w_push    = i_uop_p && !o_stall && !w_bypass;

    always_comb begin
        o_sched_uop_p = '0;
        o_sched_uop   = '0;
        w_clr_en      = 1'b0;
        w_clr_pr      = '0;
        if (w_bypass) begin
            o_sched_uop_p[i_uop_sched] = 1'b1;
            o_sched_uop                = i_uop;
            w_clr_en                   = i_uop_dst_we;
            w_clr_pr                   = i_uop_dst_pr;
        end else if (r_count != 2'd0) begin
            o_sched_uop = r_uop[r_head];
            if (w_head_go) begin
                o_sched_uop_p[r_sch[r_head]] = 1'b1;
                w_clr_en                     = r_we[r_head];
                w_clr_pr                     = r_pr[r_head];
            end
        end
    end

    // Writeback sets first so a same-edge despatch clear overrides it.
    always_comb begin
        w_pr_next = r_pr_valid;
        for (int k = 0; k < NUM_WB_PORTS; k++) begin
            if (i_wb_p[k]) begin
                w_pr_next[i_wb_pr[k*PR_W +: PR_W]] = 1'b1;
            end
        end
        if (w_clr_en) begin
            w_pr_next[w_clr_pr] = 1'b0;
        end
        w_pr_next[0] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_uop[w_tail] <= i_uop;
            r_sch[w_tail] <= i_uop_sched;
            r_we[w_tail]  <= i_uop_dst_we;
            r_pr[w_tail]  <= i_uop_dst_pr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_pr_valid <= '1;
        end else begin
            if (w_head_go) begin
                r_head <= ~r_head;
            end
            r_count    <= r_count + {1'b0, w_push} - {1'b0, w_head_go};
            r_pr_valid <= w_pr_next;
        end
    end

    assign o_pr_valid = r_pr_valid | {{(NUM_PHYSICAL_REGS-1){1'b0}}, 1'b1};
endmodule
